// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: decodes 6502 bus requests into work RAM, PPU, PRG ROM,
// controller-port and OAM DMA accesses; read data returns one cycle later.
module cpu_bus_responder #(
  parameter int RAM_AW = 11,
  parameter int PRG_AW = 15
) (
  input  logic              clk_ph2,
  input  logic              rst,
  input  logic              req,
  input  logic              rw,
  input  logic [15:0]       addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic              rvalid,
  output logic              ppu_cs,
  output logic [2:0]        ppu_reg,
  output logic              ppu_we,
  input  logic [7:0]        ppu_rdata,
  output logic [PRG_AW-1:0] prg_addr,
  input  logic [7:0]        prg_rdata,
  input  logic [7:0]        joy1,
  input  logic [7:0]        joy2,
  output logic              dma_start,
  output logic [7:0]        dma_page
);

  logic              sel_ram;
  logic              sel_ppu;
  logic              sel_prg;
  logic              sel_dma;
  logic              sel_joy1;
  logic              sel_joy2;
  logic [RAM_AW-1:0] ram_idx;

  assign sel_ram  = (addr[15:13] == 3'b000);
  assign sel_ppu  = (addr[15:13] == 3'b001);
  assign sel_prg  = addr[15];
  assign sel_dma  = (addr == 16'h4014);
  assign sel_joy1 = (addr == 16'h4016);
  assign sel_joy2 = (addr == 16'h4017);
  assign ram_idx  = addr[RAM_AW-1:0];

  assign ppu_cs   = req && sel_ppu;
  assign ppu_reg  = addr[2:0];
  assign ppu_we   = ppu_cs && !rw;
  assign prg_addr = addr[PRG_AW-1:0];

  logic [7:0] ram_q [2**RAM_AW];

  always_ff @(posedge clk_ph2) begin
    if (req && !rw && sel_ram) begin
      ram_q[ram_idx] <= wdata;
    end
  end

  logic [7:0] rdata_q, rdata_d;
  logic       rvalid_q, rvalid_d;
  logic       dma_start_q, dma_start_d;
  logic [7:0] dma_page_q, dma_page_d;
  logic       strobe_q, strobe_d;
  logic [7:0] sh1_q, sh1_d;
  logic [7:0] sh2_q, sh2_d;
  logic       joy1_bit;
  logic       joy2_bit;

  // While strobed the port reflects the live A button instead of the latch.
  assign joy1_bit = strobe_q ? joy1[0] : sh1_q[0];
  assign joy2_bit = strobe_q ? joy2[0] : sh2_q[0];

  always_comb begin
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    dma_start_d = 1'b0;
    dma_page_d  = dma_page_q;
    strobe_d    = strobe_q;
    sh1_d       = sh1_q;
    sh2_d       = sh2_q;

    if (strobe_q) begin
      sh1_d = joy1;
      sh2_d = joy2;
    end

    if (req && rw) begin
      rvalid_d = 1'b1;
      if (sel_ram) begin
        rdata_d = ram_q[ram_idx];
      end else if (sel_ppu) begin
        rdata_d = ppu_rdata;
      end else if (sel_prg) begin
        rdata_d = prg_rdata;
      end else if (sel_joy1) begin
        rdata_d = {7'b0100000, joy1_bit};
        if (!strobe_q) begin
          sh1_d = {1'b1, sh1_q[7:1]};
        end
      end else if (sel_joy2) begin
        rdata_d = {7'b0100000, joy2_bit};
        if (!strobe_q) begin
          sh2_d = {1'b1, sh2_q[7:1]};
        end
      end
    end

    // A new strobe value only affects reloading from the following cycle.
    if (req && !rw) begin
      if (sel_dma) begin
        dma_page_d  = wdata;
        dma_start_d = 1'b1;
      end
      if (sel_joy1) begin
        strobe_d = wdata[0];
      end
    end
  end

  always_ff @(posedge clk_ph2) begin
    if (rst) begin
      rdata_q     <= 8'h00;
      rvalid_q    <= 1'b0;
      dma_start_q <= 1'b0;
      dma_page_q  <= 8'h00;
      strobe_q    <= 1'b0;
      sh1_q       <= 8'hFF;
      sh2_q       <= 8'hFF;
    end else begin
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      dma_start_q <= dma_start_d;
      dma_page_q  <= dma_page_d;
      strobe_q    <= strobe_d;
      sh1_q       <= sh1_d;
      sh2_q       <= sh2_d;
    end
  end

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign dma_start = dma_start_q;
  assign dma_page  = dma_page_q;

endmodule

// File: doc/cpu_bus_responder.md
# cpu_bus_responder

Memory-side responder for the 6502 core's address/data bus. It decodes each CPU bus request and serves it:
- 2 KB internal work RAM, mirrored.
- PPU register window.
- PRG ROM window.
- Serial controller ports at $4016/$4017.
- OAM DMA trigger at $4014.

Read data returns one cycle after the request, so the CPU can latch it as its data-latch input. Unmapped reads return open-bus data, which is the last value driven.

## Interface

Parameters:
- RAM_AW, 11, work RAM address width. Array is 2^RAM_AW bytes and is indexed by addr[RAM_AW-1:0].
- PRG_AW, 15, PRG ROM address width. 15 gives 32 KB; 14 gives 16 KB mirrored at $8000 and $C000.

Ports (one clock; reset is synchronous and active-high):
- clk_ph2  in  1  sole clock; every register updates on its rising edge
- rst  in  1  synchronous, active-high reset
- req  in  1  bus request valid this cycle
- rw  in  1  1 = read, 0 = write
- addr  in  16  CPU address
- wdata  in  8  write data
- rdata  out  8  read data, registered
- rvalid  out  1  one-cycle pulse marking rdata valid
- ppu_cs  out  1  combinational; req && addr in $2000–$3FFF
- ppu_reg  out  3  combinational; addr[2:0]
- ppu_we  out  1  combinational; ppu_cs && !rw
- ppu_rdata  in  8  PPU read data, combinational, sampled at the request edge
- prg_addr  out  PRG_AW  combinational; addr[PRG_AW-1:0]
- prg_rdata  in  8  asynchronous ROM data, sampled at the request edge
- joy1, joy2  in  8  live button states; bit0 = A, then B, Select, Start, Up, Down, Left, Right
- dma_start  out  1  one-cycle pulse on a write to $4014
- dma_page  out  8  page latched by the $4014 write

## Operation

Address map (by addr[15:13] and low bits):
- $0000–$1FFF: RAM.
  - Read returns ram[addr[RAM_AW-1:0]].
  - Write stores wdata.
- $2000–$3FFF: PPU window, mirrored every 8 bytes.
  - Read returns ppu_rdata.
  - Write is forwarded on ppu_we with the CPU's wdata; this block adds no data port.
- $4014 write: dma_page <= wdata; dma_start = 1 the following cycle.
- $4016 write: strobe <= wdata[0].
- $4016 / $4017 read: controller 1 / 2 (see controller port).
- $8000–$FFFF: PRG ROM.
  - Read returns prg_rdata.
  - Write is ignored and has no side effects.
- All other addresses:
  - Read returns open bus, i.e. rdata holds its previous value; rvalid still pulses.
  - Write is ignored.

Controller port (two 8-bit shift registers, sh1 and sh2):
- While strobe = 1: every cycle sh1 <= joy1 and sh2 <= joy2.
  - A read returns bit0 of the live joy input and does not shift.
- While strobe = 0: a read of $4016 returns sh1[0], then sh1 <= {1'b1, sh1[7:1]}. $4017 behaves the same with sh2.
  - After 8 reads the port returns 1 indefinitely.
- Controller read byte = {3'b010, 4'b0000, bit}, giving $40 or $41.
- A write of 0 to strobe stops reloading. The registers then hold the values loaded on the final strobe = 1 cycle.

## Timing

- Reset values:
  - rdata = $00, rvalid = 0, dma_start = 0, dma_page = $00.
  - strobe = 0, sh1 = sh2 = $FF.
  - RAM contents are not reset.
- Read latency: 1 cycle. A request at edge N produces rdata/rvalid after edge N+1.
- One request per cycle. Back-to-back requests are fully supported with no stall.
- Write latency:
  - RAM is written at the request edge.
  - A read of the same address in the next cycle returns the new value.
- rvalid = 0 for writes and for cycles with req = 0.
- rdata holds its value when rvalid = 0.
- The ppu_* and prg_addr outputs are combinational from the request inputs. The external sources must settle within the same cycle.
- rst has priority over req in the same cycle. A request accepted in the cycle before rst asserts produces no rvalid if rst is high at the return edge.
- A $4016 write and reload in the same cycle: the new strobe takes effect from the next cycle.
- A $4014 write while dma_start is pulsing: the page is overwritten and the pulse re-fires in the next cycle.

## Test plan

- **RAM mirror**
  - Stimulus: write $A5 to $0012; read $0812, $1012, $1812.
  - Required: each read returns $A5 one cycle later with rvalid = 1.
- **PRG window, PRG_AW = 14**
  - Stimulus: read $8003 and $C003 with prg_rdata = $4C.
  - Required: both reads return $4C; prg_addr = $0003 for both; a write to $8003 leaves RAM and outputs unchanged.
- **Controller**
  - Stimulus: joy1 = $09; write $4016 ← 1, then ← 0; read $4016 ten times.
  - Required: returns $41, $40, $40, $41, $40, $40, $40, $40, $41, $41.
- **Strobe held**
  - Stimulus: strobe = 1, joy1 = $01; read $4016 three times.
  - Required: $41 each time; sh1 is not shifted.
- **PPU / open bus / DMA**
  - Stimulus 1: read $3FFA with ppu_rdata = $77.
    - Required: rdata = $77 and ppu_reg = 2 during the request cycle.
  - Stimulus 2: read $5000.
    - Required: rdata stays $77.
  - Stimulus 3: write $4014 ← $02.
    - Required: one dma_start pulse with dma_page = $02.
- **Reset mid-operation**
  - Stimulus: issue a read of $0012 and assert rst on the next cycle.
  - Required: rvalid = 0 and rdata = $00 after reset; sh1 = $FF, so a following $4016 read returns $41.
